// File: rtl/seven_seg_scan_decoder.sv
// Reads a multiplexed active-low seven-segment bus and rebuilds the hex word shown,
// loading outputs atomically once every digit has been captured in a frame.
module seven_seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   anode,
  input  logic [6:0]              sevenSeg,
  output logic [4*NUM_DIGITS-1:0] hexOut,
  output logic [NUM_DIGITS-1:0]   digitValid,
  output logic                    frameValid,
  output logic                    frameError,
  output logic                    updateStrobe
);

  localparam int BUS_W = NUM_DIGITS + 7;

  typedef enum logic {COLLECT, LOAD} state_t;

  state_t                  state, state_next;
  logic [BUS_W-1:0]        bus, prev_bus;
  logic [7:0]              count;
  logic                    armed;
  logic [4*NUM_DIGITS-1:0] staging;
  logic [NUM_DIGITS-1:0]   staging_valid, seen, seen_next, sel;
  logic                    changed, sample, one_hot, is_blank, glyph_ok;
  logic                    accept, bad, load;
  logic [3:0]              glyph_val;

  assign bus     = {anode, sevenSeg};
  assign changed = (bus != prev_bus);
  assign sample  = !changed && armed && (count == 8'(SETTLE_CYCLES - 1));
  assign sel     = ~anode;
  assign one_hot = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
  assign is_blank = (sevenSeg == 7'b1111111);
  assign load    = (state == LOAD);

  always_comb begin
    glyph_ok  = 1'b1;
    glyph_val = 4'h0;
    case (sevenSeg)
      7'b1000000: glyph_val = 4'h0;
      7'b1111001: glyph_val = 4'h1;
      7'b0100100: glyph_val = 4'h2;
      7'b0110000: glyph_val = 4'h3;
      7'b0011001: glyph_val = 4'h4;
      7'b0010010: glyph_val = 4'h5;
      7'b0000010: glyph_val = 4'h6;
      7'b1111000: glyph_val = 4'h7;
      7'b0000000: glyph_val = 4'h8;
      7'b0010000: glyph_val = 4'h9;
      7'b0001000: glyph_val = 4'hA;
      7'b0000011: glyph_val = 4'hB;
      7'b1000110: glyph_val = 4'hC;
      7'b0100001: glyph_val = 4'hD;
      7'b0000110: glyph_val = 4'hE;
      7'b0001110: glyph_val = 4'hF;
      default:    glyph_ok  = 1'b0;
    endcase
  end

  // All-high anodes is a blanking gap; anything else that is not a clean glyph is an error.
  assign accept = sample && one_hot && (glyph_ok || is_blank);
  assign bad    = sample && (sel != '0) && !(one_hot && (glyph_ok || is_blank));

  // The LOAD cycle clears the mask but still keeps a sample arriving in that same cycle.
  always_comb begin
    seen_next = load ? '0 : seen;
    if (bad)
      seen_next = '0;
    else if (accept)
      seen_next = seen_next | sel;
  end

  always_comb begin
    state_next = COLLECT;
    if (seen_next == '1)
      state_next = LOAD;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= COLLECT;
    else
      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_bus      <= '0;
      count         <= '0;
      armed         <= 1'b1;
      seen          <= '0;
      staging       <= '0;
      staging_valid <= '0;
      hexOut        <= '0;
      digitValid    <= '0;
      frameValid    <= 1'b0;
      frameError    <= 1'b0;
      updateStrobe  <= 1'b0;
    end else begin
      prev_bus <= bus;
      if (changed) begin
        count <= '0;
        armed <= 1'b1;
      end else begin
        if (count != 8'(SETTLE_CYCLES))
          count <= count + 8'd1;
        if (sample)
          armed <= 1'b0;
      end

      seen         <= seen_next;
      updateStrobe <= load;

      if (load) begin
        hexOut     <= staging;
        digitValid <= staging_valid;
        frameValid <= 1'b1;
        frameError <= 1'b0;
      end

      if (accept) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (sel[i]) begin
            staging[i*4 +: 4] <= glyph_ok ? glyph_val : 4'h0;
            staging_valid[i]  <= glyph_ok;
          end
        end
      end

      if (bad) begin
        frameError <= 1'b1;
        frameValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder: scan table with a frame scoreboard plus
// hand-written sequences for latency, errors, ghosting and mid-frame reset.
module tb_seven_seg_scan_decoder;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0010000, GA = 7'b0001000, GB = 7'b0000011;
  localparam logic [6:0] GC = 7'b1000110, GD = 7'b0100001, GE = 7'b0000110;
  localparam logic [6:0] GF = 7'b0001110, BL = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  anode;
  logic [6:0]  sevenSeg;
  logic [15:0] hexOut;
  logic [3:0]  digitValid;
  logic        frameValid, frameError, updateStrobe;

  int total = 0;
  int bad = 0;
  int strobes = 0;
  logic [19:0] exp_q[$];

  typedef struct {
    logic [6:0]  s3, s2, s1, s0;
    logic [15:0] hex;
    logic [3:0]  dv;
  } vec_t;
  vec_t tbl[5];

  seven_seg_scan_decoder #(.NUM_DIGITS(4), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .anode(anode), .sevenSeg(sevenSeg),
    .hexOut(hexOut), .digitValid(digitValid), .frameValid(frameValid),
    .frameError(frameError), .updateStrobe(updateStrobe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
    anode    = an;
    sevenSeg = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] s3, s2, s1, s0, input int n);
    show(4'b0111, s3, n);
    show(4'b1011, s2, n);
    show(4'b1101, s1, n);
    show(4'b1110, s0, n);
    show(4'b1111, BL, 4);
  endtask

  // Scoreboard: every strobe must match the oldest expected frame.
  always @(negedge clk) begin
    if (!reset && updateStrobe) begin
      strobes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'(updateStrobe), 32'd0);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        chk("frame_hex", 32'(hexOut), 32'(e[19:4]));
        chk("frame_dv", 32'(digitValid), 32'(e[3:0]));
        chk("frame_valid", 32'(frameValid), 32'd1);
        chk("frame_err_clr", 32'(frameError), 32'd0);
      end
    end
  end

  initial begin
    int s0;
    tbl[0] = '{G4, GF, G0, GB, 16'h4F0B, 4'hF};
    tbl[1] = '{G1, BL, G2, G3, 16'h1023, 4'b1011};
    tbl[2] = '{GA, GC, GD, GE, 16'hACDE, 4'hF};
    tbl[3] = '{G5, G6, G7, G9, 16'h5679, 4'hF};
    tbl[4] = '{BL, BL, BL, BL, 16'h0000, 4'h0};

    reset = 1'b1;
    anode = 4'hF;
    sevenSeg = BL;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_hex", 32'(hexOut), 32'd0);
    chk("rst_dv", 32'(digitValid), 32'd0);
    chk("rst_fv", 32'(frameValid), 32'd0);
    chk("rst_fe", 32'(frameError), 32'd0);
    chk("rst_strobe", 32'(updateStrobe), 32'd0);

    // Each digit held one cycle short of the settle time: never sampled.
    scan(G4, GF, G0, GB, 3);
    scan(G1, G2, G3, G4, 3);
    chk("short_no_strobe", 32'(strobes), 32'd0);
    chk("short_hex", 32'(hexOut), 32'd0);

    // Strobe latency: digit 0 sampled on 5th edge, strobe visible after 6th.
    exp_q.push_back({16'h4F0B, 4'hF});
    show(4'b0111, G4, 8);
    show(4'b1011, GF, 8);
    show(4'b1101, G0, 8);
    anode = 4'b1110;
    sevenSeg = GB;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("latency_k%0d", k), 32'(updateStrobe), (k == 6) ? 32'd1 : 32'd0);
    end
    show(4'b1111, BL, 4);
    chk("latency_count", 32'(strobes), 32'd1);

    for (int i = 0; i < 5; i++) begin
      s0 = strobes;
      exp_q.push_back({tbl[i].hex, tbl[i].dv});
      scan(tbl[i].s3, tbl[i].s2, tbl[i].s1, tbl[i].s0, 8);
      chk($sformatf("tbl%0d_strobe", i), 32'(strobes), 32'(s0 + 1));
      chk($sformatf("tbl%0d_fv", i), 32'(frameValid), 32'd1);
    end

    // Illegal pattern on digit 1, then recovery with a clean scan.
    show(4'b1101, 7'b0101010, 8);
    chk("illegal_fe", 32'(frameError), 32'd1);
    chk("illegal_fv", 32'(frameValid), 32'd0);
    s0 = strobes;
    exp_q.push_back({16'h8888, 4'hF});
    scan(G8, G8, G8, G8, 8);
    chk("recover_strobe", 32'(strobes), 32'(s0 + 1));
    chk("recover_hex", 32'(hexOut), 32'h8888);

    // Ghosting, then a long blanking gap that must stay quiet.
    s0 = strobes;
    show(4'b1100, G8, 8);
    chk("ghost_fe", 32'(frameError), 32'd1);
    chk("ghost_fv", 32'(frameValid), 32'd0);
    show(4'b1111, BL, 20);
    chk("blank_fe", 32'(frameError), 32'd1);
    chk("blank_no_strobe", 32'(strobes), 32'(s0));

    // Reset after three digits discards the partial frame.
    show(4'b0111, G2, 8);
    show(4'b1011, G2, 8);
    show(4'b1101, G2, 8);
    show(4'b1111, BL, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_hex", 32'(hexOut), 32'd0);
    chk("midrst_fe", 32'(frameError), 32'd0);
    chk("midrst_fv", 32'(frameValid), 32'd0);
    s0 = strobes;
    show(4'b1110, G1, 8);
    show(4'b1111, BL, 8);
    chk("midrst_no_strobe", 32'(strobes), 32'(s0));
    exp_q.push_back({16'h2221, 4'hF});
    scan(G2, G2, G2, G1, 8);
    chk("midrst_strobe", 32'(strobes), 32'(s0 + 1));
    chk("midrst_hex_final", 32'(hexOut), 32'h2221);

    chk("pending_frames", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
